ex_mem_pipe_reg: RTL and testbench

Parametrised EX→MEM pipeline register with a valid/ready handshake, flush and backpressure. It replaces the free-running EX/MEM flop bank. The MEM stage can stall the EX stage, and a branch redirect can squash in-flight entries. Downstream side effects are qualified with the valid bit. A saturating stall counter feeds performance monitoring.

---
 rtl/ex_mem_pipe_reg_pkg.sv | 31 +++
 rtl/ex_mem_pipe_reg_if.sv | 38 +++
 rtl/ex_mem_pipe_reg_slot.sv | 50 +++++
 rtl/ex_mem_pipe_reg.sv | 141 ++++++++++++++
 tb/tb_ex_mem_pipe_reg.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_mem_pipe_reg_pkg.sv
// ============================================================================
// Module : ex_mem_pipe_reg_pkg
// Brief  : Shared widths, payload width helper and skid-slot state encodings.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ex_mem_pipe_reg_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RD_W_DEF = 5;
  localparam int PAYLOAD_W_DEF = 3 * XLEN_DEF + RD_W_DEF + 4;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  typedef struct packed {
    logic taken;
    logic we;
    logic ld;
    logic str;
  } ctrl_t;

  function automatic int payload_w(input int xlen, input int rd_w);
    return 3 * xlen + rd_w + 4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_mem_pipe_reg_if.sv
// ============================================================================
// Module : ex_mem_pipe_reg_if
// Brief  : Valid/ready pipeline bus carrying the EX->MEM payload.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface ex_mem_pipe_reg_if
  import ex_mem_pipe_reg_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RD_W = RD_W_DEF
) ();

  logic            valid;
  logic            ready;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] a2;
  logic [XLEN-1:0] b2;
  logic [RD_W-1:0] rd;
  logic            taken;
  logic            we;
  logic            ld;
  logic            str;

  modport master (
    output valid, alu_out, a2, b2, rd, taken, we, ld, str,
    input  ready
  );

  modport slave (
    input  valid, alu_out, a2, b2, rd, taken, we, ld, str,
    output ready
  );

endinterface

`default_nettype wire

// File: rtl/ex_mem_pipe_reg_slot.sv
// ============================================================================
// Module : ex_mem_pipe_reg_slot
// Brief  : One pipeline entry: valid bit plus payload, with load and clear.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ex_mem_pipe_reg_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Clear only drops the valid bit; the payload keeps its last value.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/ex_mem_pipe_reg.sv
// ============================================================================
// Module : ex_mem_pipe_reg
// Brief  : EX->MEM pipeline register with valid/ready, flush and a saturating
//          stall counter. Define EX_MEM_SKID_EN for a registered-ready skid slot.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ex_mem_pipe_reg
  import ex_mem_pipe_reg_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int RD_W        = RD_W_DEF,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  ex_mem_pipe_reg_if.slave       ex_s,
  ex_mem_pipe_reg_if.master      mem_m,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam int PW = payload_w(XLEN, RD_W);

  logic [PW-1:0]          w_ex_pl;
  logic [PW-1:0]          w_main_pl;
  logic                   w_main_valid;
  logic                   w_ex_ready;
  logic                   w_accept;
  logic                   w_consume;
  logic                   w_main_ld;
  logic                   w_main_clr;
  ctrl_t                  w_ctrl;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign w_ex_pl   = {ex_s.alu_out, ex_s.a2, ex_s.b2, ex_s.rd,
                      ex_s.taken, ex_s.we, ex_s.ld, ex_s.str};
  assign w_accept  = ex_s.valid & w_ex_ready;
  assign w_consume = w_main_valid & mem_m.ready;
  assign ex_s.ready = w_ex_ready;

`ifdef EX_MEM_SKID_EN
  logic          w_skid_valid;
  logic [PW-1:0] w_skid_pl;
  logic [PW-1:0] w_main_d;
  logic [1:0]    w_state;
  logic          w_skid_ld, w_skid_clr, w_main_from_skid;

  // The slot valid bits are the state register: main is always the oldest.
  assign w_state    = w_skid_valid ? FULL : (w_main_valid ? ONE : EMPTY);
  assign w_ex_ready = !flush_i && (w_state != FULL);

  always_comb begin
    w_main_ld        = 1'b0;
    w_main_clr       = 1'b0;
    w_skid_ld        = 1'b0;
    w_skid_clr       = 1'b0;
    w_main_from_skid = 1'b0;
    if (flush_i) begin
      w_main_clr = 1'b1;
      w_skid_clr = 1'b1;
    end else begin
      case (w_state)
        EMPTY: w_main_ld = w_accept;
        ONE: begin
          if (w_accept && !w_consume)      w_skid_ld  = 1'b1;
          else if (w_accept && w_consume)  w_main_ld  = 1'b1;
          else if (w_consume)              w_main_clr = 1'b1;
        end
        FULL: begin
          if (w_consume) begin
            w_main_ld        = 1'b1;
            w_main_from_skid = 1'b1;
            w_skid_clr       = 1'b1;
          end
        end
        default: begin
          w_main_clr = 1'b1;
          w_skid_clr = 1'b1;
        end
      endcase
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_pl : w_ex_pl;

  ex_mem_pipe_reg_slot #(.W(PW)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (w_skid_ld),
    .clear_i (w_skid_clr),
    .data_i  (w_ex_pl),
    .valid_o (w_skid_valid),
    .data_o  (w_skid_pl)
  );
`else
  logic [PW-1:0] w_main_d;

  assign w_ex_ready = !flush_i && (!w_main_valid || mem_m.ready);
  assign w_main_ld  = w_accept;
  assign w_main_clr = flush_i || (w_consume && !w_accept);
  assign w_main_d   = w_ex_pl;
`endif

  ex_mem_pipe_reg_slot #(.W(PW)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (w_main_ld),
    .clear_i (w_main_clr),
    .data_i  (w_main_d),
    .valid_o (w_main_valid),
    .data_o  (w_main_pl)
  );

  assign w_ctrl        = ctrl_t'(w_main_pl[3:0]);
  assign mem_m.valid   = w_main_valid;
  assign mem_m.alu_out = w_main_pl[PW-1 -: XLEN];
  assign mem_m.a2      = w_main_pl[PW-1-XLEN -: XLEN];
  assign mem_m.b2      = w_main_pl[RD_W+4 +: XLEN];
  assign mem_m.rd      = w_main_pl[4 +: RD_W];
  assign mem_m.taken   = w_ctrl.taken & w_main_valid;
  assign mem_m.we      = w_ctrl.we    & w_main_valid;
  assign mem_m.ld      = w_ctrl.ld    & w_main_valid;
  assign mem_m.str     = w_ctrl.str   & w_main_valid;

  // Flush leaves the counter alone; only reset clears it.
  assign stall_cnt_d = (w_main_valid && !mem_m.ready && (stall_cnt_q != '1))
                     ? stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1}
                     : stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_pipe_reg.sv
// ============================================================================
// Module : tb_ex_mem_pipe_reg
// Brief  : Scoreboard bench for ex_mem_pipe_reg (base or EX_MEM_SKID_EN build).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ex_mem_pipe_reg;

  localparam int XLEN = 32;
  localparam int RD_W = 5;
  localparam int SCW  = 4;
  localparam int PW   = 3 * XLEN + RD_W + 4;
`ifdef EX_MEM_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           flush = 1'b0;
  logic [SCW-1:0] stall_cnt;

  always #5 clk = ~clk;

  ex_mem_pipe_reg_if #(.XLEN(XLEN), .RD_W(RD_W)) ex_bus ();
  ex_mem_pipe_reg_if #(.XLEN(XLEN), .RD_W(RD_W)) mem_bus ();

  ex_mem_pipe_reg #(.XLEN(XLEN), .RD_W(RD_W), .STALL_CNT_W(SCW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .ex_s        (ex_bus),
    .mem_m       (mem_bus),
    .stall_cnt_o (stall_cnt)
  );

  int            errors = 0;
  int            checks = 0;
  logic          mon_en = 1'b0;
  logic [PW-1:0] sb[$];
  logic [PW-1:0] mon_got, mon_exp;

  function automatic logic [PW-1:0] mk(input logic [31:0] v);
    return {v, v ^ 32'hA5A5_5A5A, ~v, v[8:4], v[3], v[2], v[1], v[0]};
  endfunction

  task automatic drive(input logic valid, input logic [31:0] v);
    ex_bus.valid = valid;
    {ex_bus.alu_out, ex_bus.a2, ex_bus.b2, ex_bus.rd,
     ex_bus.taken, ex_bus.we, ex_bus.ld, ex_bus.str} = mk(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    mem_bus.ready = 1'b0;
    drive(1'b0, 32'h0);
    tick();
    tick();
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Scoreboard: pop on every consume, and check control gating when idle.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      mon_got = {mem_bus.alu_out, mem_bus.a2, mem_bus.b2, mem_bus.rd,
                 mem_bus.taken, mem_bus.we, mem_bus.ld, mem_bus.str};
      if (mem_bus.valid && mem_bus.ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got %h, required no output", mon_got);
        end else begin
          mon_exp = sb.pop_front();
          if (mon_got !== mon_exp) begin
            errors++;
            $display("FAIL sb_payload: got %h, required %h", mon_got, mon_exp);
          end
        end
      end else if (!mem_bus.valid) begin
        checks++;
        if (mon_got[3:0] !== 4'b0000) begin
          errors++;
          $display("FAIL ctrl_gate: got %b, required 0000", mon_got[3:0]);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    mem_bus.ready = 1'b0;
    drive(1'b0, 32'h0);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (ex_bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", ex_bus.ready); end
    checks++; if (mem_bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", mem_bus.valid); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_stall: got %0d, required 0", stall_cnt); end
    tick();
    drive(1'b1, 32'hAF);
    sb.push_back(mk(32'hAF));
    tick();
    drive(1'b1, 32'hBF);
    tick();
    tick();
    checks++; if (mem_bus.we !== 1'b1) begin errors++; $display("FAIL pre_reset_we: got %b, required 1", mem_bus.we); end
    checks++; if (stall_cnt !== 4'd2) begin errors++; $display("FAIL pre_reset_stall: got %0d, required 2", stall_cnt); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_bus.valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b, required 0", mem_bus.valid); end
    checks++; if (mem_bus.we !== 1'b0) begin errors++; $display("FAIL async_we: got %b, required 0", mem_bus.we); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL async_stall: got %0d, required 0", stall_cnt); end
    checks++; if (mem_bus.alu_out !== 32'h0) begin errors++; $display("FAIL async_payload: got %h, required 0", mem_bus.alu_out); end
    sb.delete();
    drive(1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (ex_bus.ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b, required 1", ex_bus.ready); end
    tick();
  endtask

  task automatic test_streaming();
    logic [31:0] ev;
    mem_bus.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h10 + i);
      @(negedge clk);
      checks++; if (ex_bus.ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b, required 1", i, ex_bus.ready); end
      if (i > 0) begin
        ev = 32'h10 + i - 1;
        checks++; if (mem_bus.valid !== 1'b1 || mem_bus.alu_out !== ev) begin
          errors++; $display("FAIL stream_out[%0d]: got %b/%h, required 1/%h", i, mem_bus.valid, mem_bus.alu_out, ev);
        end
      end
      sb.push_back(mk(32'h10 + i));
      tick();
    end
    drive(1'b0, 32'h0);
    @(negedge clk);
    checks++; if (mem_bus.valid !== 1'b1 || mem_bus.alu_out !== 32'h17) begin
      errors++; $display("FAIL stream_last: got %b/%h, required 1/00000017", mem_bus.valid, mem_bus.alu_out);
    end
    tick();
    @(negedge clk);
    checks++; if (mem_bus.valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b, required 0", mem_bus.valid); end
    tick();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL stream_sb_left: got %0d, required 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    int          n;
    logic        exp_rdy;
    logic [31:0] nxt;
    apply_reset();
    mem_bus.ready = 1'b0;
    n   = 0;
    nxt = 32'h20;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, nxt);
      @(negedge clk);
      exp_rdy = (n < CAP);
      checks++; if (ex_bus.ready !== exp_rdy) begin errors++; $display("FAIL bp_ready[%0d]: got %b, required %b", c, ex_bus.ready, exp_rdy); end
      if (c > 0) begin
        checks++; if (mem_bus.valid !== 1'b1 || mem_bus.alu_out !== 32'h20) begin
          errors++; $display("FAIL bp_hold[%0d]: got %b/%h, required 1/00000020", c, mem_bus.valid, mem_bus.alu_out);
        end
      end
      if (exp_rdy) begin
        sb.push_back(mk(nxt));
        n++;
        nxt++;
      end
      tick();
    end
    checks++; if (stall_cnt !== 4'd5) begin errors++; $display("FAIL bp_stall: got %0d, required 5", stall_cnt); end
    drive(1'b0, 32'h0);
    mem_bus.ready = 1'b1;
    repeat (CAP + 1) tick();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL bp_sb_left: got %0d, required 0", sb.size()); end
  endtask

  task automatic test_flush();
    apply_reset();
    mem_bus.ready = 1'b0;
    for (int c = 0; c < CAP; c++) begin
      drive(1'b1, 32'h37 + 8 * c);
      sb.push_back(mk(32'h37 + 8 * c));
      tick();
    end
    drive(1'b0, 32'h0);
    tick();
    drive(1'b1, 32'h4F);
    flush = 1'b1;
    mem_bus.ready = 1'b1;
    @(negedge clk);
    checks++; if (ex_bus.ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b, required 0", ex_bus.ready); end
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    sb.delete();
    @(negedge clk);
    checks++; if (mem_bus.valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b, required 0", mem_bus.valid); end
    checks++; if (mem_bus.we !== 1'b0) begin errors++; $display("FAIL flush_we: got %b, required 0", mem_bus.we); end
    checks++; if (stall_cnt !== 4'(CAP)) begin errors++; $display("FAIL flush_stall: got %0d, required %0d", stall_cnt, CAP); end
    tick();
    tick();
    @(negedge clk);
    checks++; if (mem_bus.valid !== 1'b0) begin errors++; $display("FAIL flush_leak: got %b, required 0", mem_bus.valid); end
    checks++; if (mem_bus.alu_out !== 32'h37) begin errors++; $display("FAIL flush_payload: got %h, required 00000037", mem_bus.alu_out); end
    tick();
  endtask

  task automatic test_saturation();
    apply_reset();
    mem_bus.ready = 1'b0;
    drive(1'b1, 32'h61);
    sb.push_back(mk(32'h61));
    tick();
    drive(1'b0, 32'h0);
    repeat (14) tick();
    checks++; if (stall_cnt !== 4'd14) begin errors++; $display("FAIL sat_14: got %0d, required 14", stall_cnt); end
    tick();
    checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_15: got %0d, required 15", stall_cnt); end
    repeat (5) tick();
    checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d, required 15", stall_cnt); end
    mem_bus.ready = 1'b1;
    tick();
    tick();
  endtask

`ifdef EX_MEM_SKID_EN
  task automatic test_ordering();
    apply_reset();
    mem_bus.ready = 1'b0;
    drive(1'b1, 32'h71);
    sb.push_back(mk(32'h71));
    tick();
    drive(1'b1, 32'h72);
    sb.push_back(mk(32'h72));
    tick();
    drive(1'b1, 32'h73);
    @(negedge clk);
    checks++; if (ex_bus.ready !== 1'b0) begin errors++; $display("FAIL order_full: got %b, required 0", ex_bus.ready); end
    tick();
    drive(1'b0, 32'h0);
    mem_bus.ready = 1'b1;
    @(negedge clk);
    checks++; if (mem_bus.valid !== 1'b1 || mem_bus.alu_out !== 32'h71) begin
      errors++; $display("FAIL order_a: got %b/%h, required 1/00000071", mem_bus.valid, mem_bus.alu_out);
    end
    tick();
    @(negedge clk);
    checks++; if (mem_bus.valid !== 1'b1 || mem_bus.alu_out !== 32'h72) begin
      errors++; $display("FAIL order_b: got %b/%h, required 1/00000072", mem_bus.valid, mem_bus.alu_out);
    end
    tick();
    @(negedge clk);
    checks++; if (mem_bus.valid !== 1'b0 || ex_bus.ready !== 1'b1) begin
      errors++; $display("FAIL order_empty: got valid %b ready %b, required 0/1", mem_bus.valid, ex_bus.ready);
    end
    tick();
  endtask
`endif

  task automatic test_random();
    int          n;
    logic        ev, hold, exp_rdy, acc, cons;
    logic [31:0] val;
    apply_reset();
    n    = 0;
    hold = 1'b0;
    ev   = 1'b0;
    val  = 32'h0;
    for (int c = 0; c < 200; c++) begin
      if (!hold) begin
        ev  = 1'($urandom_range(0, 1));
        val = $urandom;
      end
      mem_bus.ready = 1'($urandom_range(0, 1));
      drive(ev, val);
      @(negedge clk);
`ifdef EX_MEM_SKID_EN
      exp_rdy = (n < 2);
`else
      exp_rdy = (n == 0) || mem_bus.ready;
`endif
      checks++; if (ex_bus.ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready[%0d]: got %b, required %b", c, ex_bus.ready, exp_rdy); end
      checks++; if (mem_bus.valid !== (n > 0)) begin errors++; $display("FAIL rnd_valid[%0d]: got %b, required %b", c, mem_bus.valid, (n > 0)); end
      acc  = ev && exp_rdy;
      cons = (n > 0) && mem_bus.ready;
      if (acc) sb.push_back(mk(val));
      n    = n + int'(acc) - int'(cons);
      hold = ev && !acc;
      tick();
    end
    drive(1'b0, 32'h0);
    mem_bus.ready = 1'b1;
    repeat (3) tick();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL rnd_sb_left: got %0d, required 0", sb.size()); end
  endtask

  initial begin
    mem_bus.ready = 1'b0;
    drive(1'b0, 32'h0);
    mon_en = 1'b1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
`ifdef EX_MEM_SKID_EN
    test_ordering();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
